// File: rtl/reg_mem_xfer_if.sv
// Bus bundle between reg_mem_xfer (slave modport) and the CPU/RAM/register-file side (master modport).
// State is mirrored on `state` so checkers can bind to the FSM without reaching into the block.
interface reg_mem_xfer_if #(
  parameter int ADDR_W = 12,
  parameter int NREGS  = 16
);
  localparam int RI_W = $clog2(NREGS);

  // start is a one-cycle request taken only while busy is low; busy stays high
  // through the done pulse, so a requester waits for done before issuing again.
  logic              start;
  logic              dir;
  logic [RI_W-1:0]   first;
  logic [RI_W-1:0]   last;
  logic [ADDR_W-1:0] base;
  logic              busy;
  logic              done;
  logic [RI_W-1:0]   reg_idx;
  logic [7:0]        reg_rdata;
  logic              reg_we;
  logic [7:0]        reg_wdata;
  logic              ram_en;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_in;
  logic [7:0]        ram_out;
  logic [ADDR_W-1:0] i_next;
  logic [2:0]        state;

  modport slave (
    input  start, dir, first, last, base, reg_rdata, ram_out,
    output busy, done, reg_idx, reg_we, reg_wdata, ram_en, ram_wr,
           ram_addr, ram_in, i_next, state
  );

  modport master (
    output start, dir, first, last, base, reg_rdata, ram_out,
    input  busy, done, reg_idx, reg_we, reg_wdata, ram_en, ram_wr,
           ram_addr, ram_in, i_next, state
  );
endinterface

// File: rtl/reg_mem_xfer.sv
// Register-range <-> RAM block mover (CHIP-8 style FX55/FX65). All bus outputs are registered.
// Optional macro XFER_I_INCREMENT_EN: i_next reports base + N on done instead of base.
module reg_mem_xfer #(
  parameter int ADDR_W  = 12,
  parameter int NREGS   = 16,
  parameter int RAM_LAT = 1
) (
  input logic            clk,
  input logic            res,
  reg_mem_xfer_if.slave  bus
);
  localparam int RI_W  = $clog2(NREGS);
  localparam int CNT_W = RI_W + 1;

  localparam logic [RI_W-1:0]   IDX_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [2:0]        LAT      = 3'(RAM_LAT);

  typedef enum logic [2:0] {
    IDLE, ST_SETUP, ST_WRITE, LD_ISSUE, LD_WAIT, LD_CAPTURE, FINISH
  } state_t;

  state_t             state_q, state_d;
  logic               step_dn_q, step_dn_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;   // next RAM address to issue
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // bytes not yet issued
  logic [2:0]         wait_q, wait_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [RI_W-1:0]    reg_idx_q, reg_idx_d;
  logic               reg_we_q, reg_we_d;
  logic [7:0]         reg_wdata_q, reg_wdata_d;
  logic               ram_en_q, ram_en_d;
  logic               ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [7:0]         ram_in_q, ram_in_d;
  logic [ADDR_W-1:0]  i_next_q, i_next_d;

  logic [RI_W-1:0]    span;
  logic [CNT_W-1:0]   n_bytes;
  logic [RI_W-1:0]    idx_step;
  logic [ADDR_W-1:0]  i_final;

  assign span     = (bus.first <= bus.last) ? (bus.last - bus.first) : (bus.first - bus.last);
  assign n_bytes  = {1'b0, span} + CNT_ONE;
  assign idx_step = step_dn_q ? (reg_idx_q - IDX_ONE) : (reg_idx_q + IDX_ONE);

`ifdef XFER_I_INCREMENT_EN
  // After the last issue addr_q has advanced exactly N places past base.
  assign i_final = addr_q;
`else
  assign i_final = base_q;
`endif

  always_comb begin
    state_d     = state_q;
    step_dn_d   = step_dn_q;
    base_d      = base_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    reg_idx_d   = reg_idx_q;
    reg_we_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    ram_en_d    = ram_en_q;
    ram_wr_d    = ram_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_in_d    = ram_in_q;
    i_next_d    = i_next_q;

    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        ram_en_d = 1'b0;
        ram_wr_d = 1'b0;
        if (bus.start) begin
          busy_d    = 1'b1;
          step_dn_d = (bus.first > bus.last);
          base_d    = bus.base;
          reg_idx_d = bus.first;
          if (bus.dir) begin
            state_d    = LD_ISSUE;
            ram_en_d   = 1'b1;
            ram_addr_d = bus.base;
            addr_d     = bus.base + ADDR_ONE;
            cnt_d      = n_bytes - CNT_ONE;
          end else begin
            state_d = ST_SETUP;
            addr_d  = bus.base;
            cnt_d   = n_bytes;
          end
        end
      end

      // Each cycle here registers the byte whose register is currently on reg_idx.
      ST_SETUP, ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d  = FINISH;
          ram_en_d = 1'b0;
          ram_wr_d = 1'b0;
          done_d   = 1'b1;
          i_next_d = i_final;
        end else begin
          state_d    = ST_WRITE;
          ram_en_d   = 1'b1;
          ram_wr_d   = 1'b1;
          ram_addr_d = addr_q;
          ram_in_d   = bus.reg_rdata;
          addr_d     = addr_q + ADDR_ONE;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q > CNT_ONE) reg_idx_d = idx_step;
        end
      end

      LD_ISSUE: begin
        if (RAM_LAT == 0) begin
          state_d     = LD_CAPTURE;
          ram_en_d    = 1'b0;
          reg_we_d    = 1'b1;
          reg_wdata_d = bus.ram_out;
        end else begin
          state_d = LD_WAIT;
          wait_d  = LAT - 3'd1;
        end
      end

      LD_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d     = LD_CAPTURE;
          ram_en_d    = 1'b0;
          reg_we_d    = 1'b1;
          reg_wdata_d = bus.ram_out;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      LD_CAPTURE: begin
        if (cnt_q == '0) begin
          state_d  = FINISH;
          done_d   = 1'b1;
          i_next_d = i_final;
        end else begin
          state_d    = LD_ISSUE;
          ram_en_d   = 1'b1;
          ram_addr_d = addr_q;
          addr_d     = addr_q + ADDR_ONE;
          cnt_d      = cnt_q - CNT_ONE;
          reg_idx_d  = idx_step;
        end
      end

      FINISH: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        ram_en_d = 1'b0;
        ram_wr_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= IDLE;
      step_dn_q   <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reg_idx_q   <= '0;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_in_q    <= '0;
      i_next_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_dn_q   <= step_dn_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      reg_idx_q   <= reg_idx_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      ram_en_q    <= ram_en_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_in_q    <= ram_in_d;
      i_next_q    <= i_next_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reg_idx   = reg_idx_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_in    = ram_in_q;
  assign bus.i_next    = i_next_q;
  assign bus.state     = state_q;
endmodule

// File: doc/reg_mem_xfer.md
REG_MEM_XFER -- requirements
Module: reg_mem_xfer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM address width.
REQ-002 SHALL have parameter NREGS, default 16, register file depth (power of two, RI_W = log2(NREGS)).
REQ-003 SHALL have parameter RAM_LAT, default 1, wait cycles between RAM address presentation and valid ram_out (0..7).
REQ-004 SHALL use one clock `clk` and a synchronous, active-high reset `res`.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 res  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle request to begin a transfer.
REQ-008 dir  in  1  0 = store registers to RAM, 1 = load RAM into registers.
REQ-009 first  in  RI_W  first register index of range.
REQ-010 last  in  RI_W  last register index of range.
REQ-011 base  in  ADDR_W  RAM address of first byte.
REQ-012 busy  out  1  transfer in progress.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 reg_idx  out  RI_W  register index being read or written.
REQ-015 reg_rdata  in  8  combinational register read data for reg_idx.
REQ-016 reg_we  out  1  register write strobe.
REQ-017 reg_wdata  out  8  register write data.
REQ-018 ram_en, ram_wr  out  1 each  RAM enable and write strobe.
REQ-019 ram_addr  out  ADDR_W; ram_in  out  8 (write data); ram_out  in  8 (read data).
REQ-020 i_next  out  ADDR_W  updated index pointer (see Configuration).

Function
REQ-021 States SHALL be IDLE, ST_SETUP, ST_WRITE, LD_ISSUE, LD_WAIT, LD_CAPTURE, FINISH.
REQ-022 start SHALL be accepted only in IDLE; start while busy SHALL be ignored with no effect on the running transfer.
REQ-023 On acceptance, first, last, base, dir SHALL be latched; later input changes SHALL not affect the transfer.
REQ-024 Byte count N SHALL equal |last - first| + 1; step SHALL be +1 when first <= last, -1 when first > last (descending range, register order reversed, RAM addresses still ascending from base).
REQ-025 Byte k (k = 0..N-1) SHALL use register first +/- k and RAM address (base + k) mod 2^ADDR_W.
REQ-026 busy SHALL be high from the cycle after acceptance until and including the done cycle.
REQ-027 Store: ST_SETUP one cycle presenting reg_idx = first; then ST_WRITE one cycle per byte with ram_en = ram_wr = 1, ram_addr/ram_in registered from current reg_idx/reg_rdata; back-to-back bytes, no gaps.
REQ-028 Store latency: acceptance at T0, writes during T2..T(N+1), done high at T(N+2) with ram_en = ram_wr = 0.
REQ-029 Load: per byte LD_ISSUE presents ram_en = 1, ram_wr = 0, ram_addr; LD_WAIT holds for RAM_LAT cycles (skipped when 0); LD_CAPTURE samples ram_out and pulses reg_we for one cycle with reg_idx, reg_wdata = ram_out.
REQ-030 Load latency: (RAM_LAT + 2) cycles per byte, done one cycle after last reg_we.
REQ-031 reg_we SHALL never assert during store; ram_wr SHALL never assert during load.
REQ-032 FINISH SHALL pulse done, deassert ram_en, and return to IDLE next cycle; start on the done cycle SHALL be ignored.

Reset
REQ-033 res SHALL force IDLE; busy, done, reg_we, ram_en, ram_wr = 0; ram_addr, ram_in, reg_idx, reg_wdata = 0; i_next = 0.
REQ-034 res asserted mid-transfer SHALL abort it: no further RAM or register strobes from the next edge, no done pulse.

Configuration
REQ-035 Macro XFER_I_INCREMENT_EN defined: on done, i_next SHALL equal (base + N) mod 2^ADDR_W (legacy CHIP-8 I advance).
REQ-036 Macro XFER_I_INCREMENT_EN undefined: i_next SHALL equal latched base on done (SCHIP semantics, I unchanged).

Verification
REQ-037 Store first=0, last=3, base=0x300, regs 0x11,0x22,0x33,0x44 -> writes 0x300..0x303 = 0x11..0x44 on T2..T5, done at T6.
REQ-038 Load first=5, last=2, base=0x400, RAM 0xA0..0xA3, RAM_LAT=1 -> V5=0xA0, V4=0xA1, V3=0xA2, V2=0xA3, 3 cycles/byte, done once.
REQ-039 Store first=last=7, base=0xFFF -> single write at 0xFFF, i_next = 0x000 with macro, 0xFFF without.
REQ-040 Store base=0xFFE, 4 bytes -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-041 Start pulse during busy with different first/base -> ignored, original transfer completes unchanged.
REQ-042 res on 2nd byte of 8-byte load -> no reg_we/ram_en after reset edge, no done, next start runs normally.
